// File: rtl/spi_slave.sv
// spi_slave: SPI target serializer/deserializer clocked directly by the bus clock.
// Supports all four CPOL/CPHA modes and multi-word frames under one csn assertion.
// A completed-word toggle and a per-frame word counter provide a CDC hook for the host.
// Optional build macro: SPI_SLAVE_MISO_TRISTATE_EN releases miso (high-Z) while the
// target is deselected or held in reset so several targets can share the line.
module spi_slave #(
    parameter int DATA_WIDTH = 8,
    parameter int CPOL       = 0,
    parameter int CPHA       = 0,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  sclk,
    input  logic                  arstn,
    input  logic                  csn,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] data_send,
    output logic [DATA_WIDTH-1:0] data_recv,
    output logic                  rx_toggle,
    output logic [CNT_WIDTH-1:0]  word_cnt,
    output logic                  busy
);

    localparam int                BIT_W    = $clog2(DATA_WIDTH);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_WIDTH - 1);
    // Fixed inversion: after it, the sample edge is always the rising edge of sck_int
    // and the shift edge is always its falling edge.
    localparam logic              EDGE_INV = (CPOL != CPHA);

    logic                  sck_int;
    logic                  cnt_clr;

    logic [BIT_W-1:0]      rx_cnt_q, rx_cnt_d;
    logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
    logic [DATA_WIDTH-2:0] rx_shreg_q, rx_shreg_d;
    logic [DATA_WIDTH-1:0] data_recv_q, data_recv_d;
    logic                  rx_toggle_q, rx_toggle_d;
    logic                  rx_last;
    logic [DATA_WIDTH-1:0] rx_word;

    logic [BIT_W-1:0]      tx_cnt_q, tx_cnt_d;
    logic [DATA_WIDTH-1:0] tx_shreg_q, tx_shreg_d;
    logic                  tx_first;
    logic                  miso_int;

    assign sck_int = sclk ^ EDGE_INV;
    // Bit/word counters are held at zero while deselected so every frame starts clean.
    assign cnt_clr = arstn | csn;

    // Receive next-state: shift mosi in, finish the word on the last bit position.
    always_comb begin
        rx_last     = (rx_cnt_q == LAST_BIT);
        rx_word     = {rx_shreg_q, mosi};
        rx_shreg_d  = rx_word[DATA_WIDTH-2:0];
        rx_cnt_d    = rx_last ? '0 : rx_cnt_q + BIT_W'(1);
        word_cnt_d  = rx_last ? word_cnt_q + CNT_WIDTH'(1) : word_cnt_q;
        data_recv_d = rx_last ? rx_word : data_recv_q;
        rx_toggle_d = rx_last ? ~rx_toggle_q : rx_toggle_q;
    end

    // Receive counters advance on the sample edge; deselect or reset clears them at once.
    always_ff @(posedge sck_int or posedge cnt_clr) begin
        if (cnt_clr) begin
            rx_cnt_q   <= '0;
            word_cnt_q <= '0;
        end else begin
            rx_cnt_q   <= rx_cnt_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // Receive data path survives deselect; a partial word never reaches data_recv because
    // the counter is cleared before it can reach the last bit position.
    always_ff @(posedge sck_int or posedge arstn) begin
        if (arstn) begin
            rx_shreg_q  <= '0;
            data_recv_q <= '0;
            rx_toggle_q <= 1'b0;
        end else begin
            rx_shreg_q  <= rx_shreg_d;
            data_recv_q <= data_recv_d;
            rx_toggle_q <= rx_toggle_d;
        end
    end

    // Transmit next-state: reload from data_send at the first shift edge of each word.
    // With CPHA=0 the MSB is already presented combinationally, so the load skips it.
    always_comb begin
        tx_first = (tx_cnt_q == '0);
        tx_cnt_d = (tx_cnt_q == LAST_BIT) ? '0 : tx_cnt_q + BIT_W'(1);
        if (tx_first) begin
            tx_shreg_d = (CPHA == 0) ? (data_send << 1) : data_send;
        end else begin
            tx_shreg_d = tx_shreg_q << 1;
        end
        miso_int = ((CPHA == 0) && tx_first) ? data_send[DATA_WIDTH-1]
                                              : tx_shreg_q[DATA_WIDTH-1];
    end

    // Transmit bit counter advances on the shift edge; cleared with the receive counters.
    always_ff @(negedge sck_int or posedge cnt_clr) begin
        if (cnt_clr) begin
            tx_cnt_q <= '0;
        end else begin
            tx_cnt_q <= tx_cnt_d;
        end
    end

    // Transmit shift register only reloads or shifts on shift edges.
    always_ff @(negedge sck_int or posedge arstn) begin
        if (arstn) begin
            tx_shreg_q <= '0;
        end else begin
            tx_shreg_q <= tx_shreg_d;
        end
    end

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign miso = (csn | arstn) ? 1'bz : miso_int;
`else
    assign miso = (csn | arstn) ? 1'b0 : miso_int;
`endif

    assign data_recv = data_recv_q;
    assign rx_toggle = rx_toggle_q;
    assign word_cnt  = word_cnt_q;
    assign busy      = (rx_cnt_q != '0);

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: drives one spi_slave per SPI mode from a bit-level master, and checks the
// outputs against a word-level model (bits counted per word, words per frame).
`timescale 1ns/1ps
module tb_spi_slave;

    localparam int DW   = 8;
    localparam int HALF = 100;   // half sclk period in ns (5 MHz)

    logic       arstn;
    logic       mosi;
    logic [7:0] data_send;
    logic [3:0] sclk_v, csn_v, miso_v, tog_v, busy_v;
    logic [7:0] recv_v [4];
    logic [7:0] wcnt_v [4];

    int total = 0;
    int bad   = 0;

    // Word-level model state per mode.
    logic [7:0] exp_recv [4];
    logic       exp_tog  [4];
    logic [7:0] exp_wcnt [4];
    int         exp_bits [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dut
            spi_slave #(
                .DATA_WIDTH(DW),
                .CPOL      (gi / 2),
                .CPHA      (gi % 2),
                .CNT_WIDTH (8)
            ) u_dut (
                .sclk     (sclk_v[gi]),
                .arstn    (arstn),
                .csn      (csn_v[gi]),
                .mosi     (mosi),
                .miso     (miso_v[gi]),
                .data_send(data_send),
                .data_recv(recv_v[gi]),
                .rx_toggle(tog_v[gi]),
                .word_cnt (wcnt_v[gi]),
                .busy     (busy_v[gi])
            );
        end
    endgenerate

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic model_reset_all();
        for (int k = 0; k < 4; k++) begin
            exp_recv[k] = '0;
            exp_tog[k]  = 1'b0;
            exp_wcnt[k] = '0;
            exp_bits[k] = 0;
        end
    endtask

    // Model update for one sampled bit: a word completes after DW bits.
    task automatic model_sample(input int m, input logic [7:0] mw);
        exp_bits[m]++;
        if (exp_bits[m] == DW) begin
            exp_bits[m] = 0;
            exp_recv[m] = mw;
            exp_tog[m]  = ~exp_tog[m];
            exp_wcnt[m] = exp_wcnt[m] + 8'd1;
        end
    endtask

    // Compare DUT outputs of mode m against the model.
    task automatic check_outputs(input int m);
        chk($sformatf("m%0d data_recv", m), 32'(recv_v[m]), 32'(exp_recv[m]));
        chk($sformatf("m%0d rx_toggle", m), 32'(tog_v[m]), 32'(exp_tog[m]));
        chk($sformatf("m%0d word_cnt", m), 32'(wcnt_v[m]), 32'(exp_wcnt[m]));
        chk($sformatf("m%0d busy", m), 32'(busy_v[m]), 32'(exp_bits[m] != 0));
    endtask

    task automatic chk_idle_miso(input int m);
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
        total++;
        if (miso_v[m] !== 1'bz) begin
            bad++;
            $display("FAIL m%0d miso_idle: got %b want z", m, miso_v[m]);
        end
`else
        chk($sformatf("m%0d miso_idle", m), 32'(miso_v[m]), 32'd0);
`endif
    endtask

    task automatic cs_low(input int m);
        csn_v[m]    = 1'b0;
        exp_bits[m] = 0;
        exp_wcnt[m] = '0;
        #(HALF);
    endtask

    task automatic cs_high(input int m);
        #(HALF);
        csn_v[m]    = 1'b1;
        exp_bits[m] = 0;
        exp_wcnt[m] = '0;
        #1;
        check_outputs(m);
        chk_idle_miso(m);
        #(HALF);
    endtask

    // Master side of one word (or its first nbits bits) in mode m.
    task automatic xfer_word(input int m, input logic [7:0] mw, input logic [7:0] sw,
                             input int nbits, output logic [7:0] got);
        logic       cpol = (m >= 2);
        logic       cpha = ((m % 2) == 1);
        logic [7:0] g    = '0;
        data_send = sw;
        #5;
        for (int b = 0; b < nbits; b++) begin
            if (!cpha) begin
                mosi = mw[7-b];
                #(HALF);
                g = {g[6:0], miso_v[m]};
                chk($sformatf("m%0d miso bit%0d", m, b), 32'(miso_v[m]), 32'(sw[7-b]));
                sclk_v[m] = ~cpol;
            end else begin
                sclk_v[m] = ~cpol;
                mosi = mw[7-b];
                #(HALF);
                g = {g[6:0], miso_v[m]};
                chk($sformatf("m%0d miso bit%0d", m, b), 32'(miso_v[m]), 32'(sw[7-b]));
                sclk_v[m] = cpol;
            end
            #1;
            model_sample(m, mw);
            check_outputs(m);
            #(HALF - 1);
            if (!cpha) sclk_v[m] = cpol;
        end
        got = g;
        $display("xfer mode=%0d mosi=%02h data_send=%02h bits=%0d miso_word=%02h",
                 m, mw, sw, nbits, g);
    endtask

    initial begin
        logic [7:0] got;
        arstn     = 1'b1;
        csn_v     = 4'hF;
        sclk_v    = 4'b1100;
        mosi      = 1'b0;
        data_send = 8'h00;
        model_reset_all();
        #20;
        for (int m = 0; m < 4; m++) begin
            check_outputs(m);
            chk($sformatf("m%0d reset miso", m), 32'(miso_v[m]), 32'd0);
        end
        arstn = 1'b0;
        #20;
        for (int m = 0; m < 4; m++) chk_idle_miso(m);

        // Mode 0 single word.
        cs_low(0);
        xfer_word(0, 8'hA5, 8'h3C, DW, got);
        chk("t1 master_rx", 32'(got), 32'h3C);
        chk("t1 data_recv", 32'(recv_v[0]), 32'hA5);
        chk("t1 toggle", 32'(tog_v[0]), 32'd1);
        chk("t1 word_cnt", 32'(wcnt_v[0]), 32'd1);
        cs_high(0);

        // Mode 0 two back-to-back words.
        cs_low(0);
        xfer_word(0, 8'hA5, 8'h3C, DW, got);
        chk("t2 master_rx0", 32'(got), 32'h3C);
        xfer_word(0, 8'h9A, 8'h5A, DW, got);
        chk("t2 master_rx1", 32'(got), 32'h5A);
        chk("t2 data_recv", 32'(recv_v[0]), 32'h9A);
        chk("t2 word_cnt", 32'(wcnt_v[0]), 32'd2);
        chk("t2 toggle", 32'(tog_v[0]), 32'd1);
        cs_high(0);

        // Mode 3 single word.
        cs_low(3);
        xfer_word(3, 8'h81, 8'hC3, DW, got);
        chk("t3 master_rx", 32'(got), 32'hC3);
        chk("t3 data_recv", 32'(recv_v[3]), 32'h81);
        cs_high(3);

        // Mode 0 abort after 3 bits, then a full word.
        cs_low(0);
        xfer_word(0, 8'hFF, 8'h00, 3, got);
        cs_high(0);
        chk("t4 toggle after abort", 32'(tog_v[0]), 32'd1);
        chk("t4 recv after abort", 32'(recv_v[0]), 32'h9A);
        cs_low(0);
        xfer_word(0, 8'h12, 8'hE7, DW, got);
        chk("t4 data_recv", 32'(recv_v[0]), 32'h12);
        chk("t4 word_cnt", 32'(wcnt_v[0]), 32'd1);
        cs_high(0);

        // Reset pulse mid-word.
        cs_low(0);
        xfer_word(0, 8'hF0, 8'hAA, 4, got);
        arstn = 1'b1;
        #1;
        model_reset_all();
        chk("t5 rst data_recv", 32'(recv_v[0]), 32'd0);
        chk("t5 rst toggle", 32'(tog_v[0]), 32'd0);
        chk("t5 rst word_cnt", 32'(wcnt_v[0]), 32'd0);
        chk("t5 rst busy", 32'(busy_v[0]), 32'd0);
        chk_idle_miso(0);
        #(HALF);
        arstn    = 1'b0;
        csn_v[0] = 1'b1;
        #(HALF);
        cs_low(0);
        xfer_word(0, 8'h66, 8'h99, DW, got);
        chk("t5 data_recv", 32'(recv_v[0]), 32'h66);
        chk("t5 master_rx", 32'(got), 32'h99);
        cs_high(0);

        // Randomized frames across all modes.
        repeat (40) begin
            int m  = int'($urandom_range(0, 3));
            int nw = int'($urandom_range(1, 3));
            cs_low(m);
            for (int w = 0; w < nw; w++) begin
                logic [7:0] mw    = 8'($urandom);
                logic [7:0] sw    = 8'($urandom);
                bit         abort = (w == nw - 1) && ($urandom_range(0, 3) == 0);
                int         nb    = abort ? int'($urandom_range(1, DW - 1)) : DW;
                xfer_word(m, mw, sw, nb, got);
                if (!abort) chk($sformatf("m%0d rand master_rx", m), 32'(got), 32'(sw));
            end
            cs_high(m);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
